// File: rtl/spi_ctrl_pkg.sv
// Shared types and helpers for the SPI master frame sequencer.
package spi_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        DONE
    } state_e;

    localparam logic SPI_WR = 1'b0;
    localparam logic SPI_RD = 1'b1;

    // Frame is {rw, addr, data}.
    function automatic int unsigned frame_len(int unsigned addr_w, int unsigned data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_xfer_ctrl_if.sv
// Host-side request/response bundle of the SPI frame sequencer.
interface spi_xfer_ctrl_if #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 32
);
    logic              req;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, wr, addr, wdata,
        input  busy, done, rdata
    );

    modport slave (
        input  req, wr, addr, wdata,
        output busy, done, rdata
    );
endinterface

// File: rtl/spi_clk_div.sv
// Free-running divider: one-cycle tick every CLK_DIV clocks while enabled.
module spi_clk_div #(
    parameter int unsigned CLK_DIV = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);
    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == CntLast);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !en_i) begin
            cnt_d = '0;
        end else if (tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Master-side SPI frame sequencer: turns one host request into a chip-selected
// {rw, addr, data} frame, MSB first, with SCL derived from clk.
module spi_xfer_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int unsigned CLK_DIV = 5,
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned DATA_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    spi_xfer_ctrl_if.slave        host,
    output logic                  spi_cs_o,
    output logic                  spi_scl_o,
    output logic                  spi_sdo_o,
    input  logic                  spi_sdi_i
);
    localparam int unsigned N    = frame_len(ADDR_W, DATA_W);
    localparam int unsigned BitW = $clog2(N + 1);
    localparam logic [BitW-1:0] BitLast   = BitW'(N);
    localparam logic [BitW-1:0] DataFirst = BitW'(1 + ADDR_W);

    state_e            state_q;
    logic [N-2:0]      shift_q;   // bits still to send; the current bit sits in sdo_q
    logic [BitW-1:0]   bit_cnt_q; // scl rising edges so far in this frame
    logic [DATA_W-1:0] rx_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rd_q;
    logic              busy_q;
    logic              done_q;
    logic              cs_q;
    logic              scl_q;
    logic              sdo_q;

    logic              accept;
    logic              tick;
    logic [DATA_W-1:0] tx_data;
    logic [N-1:0]      frame_in;

    assign accept   = (state_q == IDLE) && host.req;
    assign tx_data  = (host.wr == SPI_RD) ? '0 : host.wdata;
    assign frame_in = {host.wr, host.addr, tx_data};

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (state_q != IDLE),
        .clr_i  (accept),
        .tick_o (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            rx_q      <= '0;
            rdata_q   <= '0;
            rd_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cs_q      <= 1'b0;
            scl_q     <= 1'b0;
            sdo_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        rd_q      <= host.wr;
                        shift_q   <= frame_in[N-2:0];
                        sdo_q     <= frame_in[N-1];
                        bit_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        cs_q      <= 1'b1;
                        scl_q     <= 1'b0;
                        state_q   <= SETUP;
                    end
                end
                SETUP: begin
                    if (tick) begin
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (!scl_q) begin
                            // Rising edge: slave samples sdo, we sample sdi.
                            scl_q     <= 1'b1;
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            if ((rd_q == SPI_RD) && (bit_cnt_q >= DataFirst)) begin
                                rx_q <= {rx_q[DATA_W-2:0], spi_sdi_i};
                            end
                        end else begin
                            scl_q   <= 1'b0;
                            sdo_q   <= shift_q[N-2];
                            shift_q <= {shift_q[N-3:0], 1'b0};
                            if (bit_cnt_q == BitLast) begin
                                state_q <= HOLD;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        state_q <= DONE;
                        cs_q    <= 1'b0;
                        done_q  <= 1'b1;
                        if (rd_q == SPI_RD) begin
                            rdata_q <= rx_q;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign host.busy  = busy_q;
    assign host.done  = done_q;
    assign host.rdata = rdata_q;
    assign spi_cs_o   = cs_q;
    assign spi_scl_o  = scl_q;
    assign spi_sdo_o  = sdo_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: two instances (CLK_DIV 5 and 2) checked cycle by cycle
// against a timing model derived from frame start, plus a done-time scoreboard.
module tb_spi_xfer_ctrl;
    import spi_ctrl_pkg::*;

    localparam int unsigned AW = 7;
    localparam int unsigned DW = 32;
    localparam int unsigned N  = frame_len(AW, DW);
    localparam int NI = 2;
    localparam int NS = int'(N);

    typedef struct packed {
        logic [31:0]   d;
        logic [DW-1:0] rd;
    } sb_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [NI-1:0]  req, wr, busy, done, cs, scl, sdo, sdi;
    logic [AW-1:0]  addr       [NI];
    logic [DW-1:0]  wdata      [NI];
    logic [DW-1:0]  rdata      [NI];
    logic [N-1:0]   slave_word [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        spi_xfer_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) hif ();
        assign hif.req   = req[g];
        assign hif.wr    = wr[g];
        assign hif.addr  = addr[g];
        assign hif.wdata = wdata[g];
        assign busy[g]   = hif.busy;
        assign done[g]   = hif.done;
        assign rdata[g]  = hif.rdata;

        spi_xfer_ctrl #(
            .CLK_DIV ((g == 0) ? 5 : 2),
            .ADDR_W  (AW),
            .DATA_W  (DW)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .host      (hif),
            .spi_cs_o  (cs[g]),
            .spi_scl_o (scl[g]),
            .spi_sdo_o (sdo[g]),
            .spi_sdi_i (sdi[g])
        );
    end

    // Reference model state, owned by the monitor process.
    int total = 0;
    int bad = 0;
    logic          armed = 1'b0;
    logic          have   [NI];
    int            t0     [NI];
    int            acc_cnt[NI];
    logic          m_idle [NI];
    logic [N-1:0]  frame  [NI];
    logic [N-1:0]  pat    [NI];
    logic [DW-1:0] rd_before [NI];
    logic [DW-1:0] rd_after  [NI];
    sb_t           sb_q [NI][$];

    task automatic chk(input string nm, input int i, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d cyc=%0d got=%0h want=%0h", nm, i, cyc, act, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            have[i] = 1'b0; t0[i] = 0; acc_cnt[i] = 0; m_idle[i] = 1'b1;
            frame[i] = '0; pat[i] = '0; rd_before[i] = '0; rd_after[i] = '0;
        end
    end

    always @(negedge clk) begin
        int c, t, cdv, d, f, r;
        logic e_busy, e_done, e_cs, e_scl, e_sdo;
        logic [DW-1:0] e_rd;
        sb_t e;
        for (int i = 0; i < NI; i++) begin
            c   = int'(cyc);
            cdv = (i == 0) ? 5 : 2;
            t   = t0[i];
            d   = t + (2 * NS + 2) * cdv;
            if (armed) begin
                if (have[i]) begin
                    e_busy = (c >= t) && (c <= d);
                    e_done = (c == d);
                    e_cs   = (c >= t) && (c < d);
                    e_scl  = (c >= t + 2 * cdv) && (c < t + (2 * NS + 1) * cdv) &&
                             (((c - t - 2 * cdv) / cdv) % 2 == 0);
                    f = (c < t + 3 * cdv) ? 0 : (c - t - 3 * cdv) / (2 * cdv) + 1;
                    if (f > NS) f = NS;
                    e_sdo  = (f < NS) ? frame[i][NS-1-f] : 1'b0;
                    e_rd   = (c >= d) ? rd_after[i] : rd_before[i];
                end else begin
                    e_busy = 1'b0; e_done = 1'b0; e_cs = 1'b0; e_scl = 1'b0; e_sdo = 1'b0;
                    e_rd   = rd_before[i];
                end
                chk("busy", i, 64'(busy[i]), 64'(e_busy));
                chk("done", i, 64'(done[i]), 64'(e_done));
                chk("cs", i, 64'(cs[i]), 64'(e_cs));
                chk("scl", i, 64'(scl[i]), 64'(e_scl));
                chk("sdo", i, 64'(sdo[i]), 64'(e_sdo));
                chk("rdata", i, 64'(rdata[i]), 64'(e_rd));

                if (done[i] === 1'b1) begin
                    chk("sb_pending", i, 64'(sb_q[i].size() != 0), 64'd1);
                    if (sb_q[i].size() != 0) begin
                        e = sb_q[i].pop_front();
                        chk("done_time", i, 64'(c), 64'(e.d));
                        chk("rdata_at_done", i, 64'(rdata[i]), 64'(e.rd));
                    end
                end else if (sb_q[i].size() != 0 && c > int'(sb_q[i][0].d)) begin
                    chk("done_timeout", i, 64'(done[i]), 64'd1);
                    void'(sb_q[i].pop_front());
                end
            end

            if (!rst_n) begin
                have[i] = 1'b0;
                m_idle[i] = 1'b1;
                sb_q[i].delete();
                rd_before[i] = '0;
                rd_after[i] = '0;
            end else if (armed) begin
                if (have[i] && c >= d) rd_before[i] = rd_after[i];
                m_idle[i] = !have[i] || (c >= d + 1);
                if (req[i] && m_idle[i]) begin
                    have[i]  = 1'b1;
                    m_idle[i] = 1'b0;
                    t0[i]    = c + 1;
                    pat[i]   = slave_word[i];
                    frame[i] = {wr[i], addr[i], (wr[i] == SPI_RD) ? {DW{1'b0}} : wdata[i]};
                    rd_after[i] = (wr[i] == SPI_RD) ? slave_word[i][DW-1:0] : rd_before[i];
                    e.d  = 32'(t0[i] + (2 * NS + 2) * cdv);
                    e.rd = rd_after[i];
                    sb_q[i].push_back(e);
                    acc_cnt[i]++;
                end
            end

            // Slave: present bit k of its word ahead of the k-th scl rise.
            t = t0[i];
            if (have[i] && rst_n) begin
                r = (c < t + 2 * cdv) ? 0 : (c - t - 2 * cdv) / (2 * cdv) + 1;
                sdi[i] = (r < NS) ? pat[i][NS-1-r] : 1'($urandom);
            end else begin
                sdi[i] = 1'($urandom);
            end
        end
        if (!rst_n) armed = 1'b1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start(input int i, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] dat, input logic [N-1:0] p, input int nacc);
        int base;
        @(posedge clk);
        #1;
        base = acc_cnt[i];
        wr[i] = w; addr[i] = a; wdata[i] = dat; slave_word[i] = p;
        req[i] = 1'b1;
        for (int k = 0; k < 4000 && acc_cnt[i] < base + nacc; k++) step(1);
        req[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        for (int k = 0; k < 4000 && !m_idle[i]; k++) step(1);
        step(2);
    endtask

    function automatic logic [N-1:0] rand_word();
        logic [63:0] tmp;
        tmp = {$urandom(), $urandom()};
        return tmp[N-1:0];
    endfunction

    initial begin
        logic [N-1:0] p;
        req = '0; wr = '0;
        for (int i = 0; i < NI; i++) begin
            addr[i] = '0; wdata[i] = '0; slave_word[i] = '0;
        end
        step(3);
        rst_n = 1'b1;
        step(2);

        // Read, then write must leave the read data in place.
        p = rand_word();
        p[DW-1:0] = 32'hA5A5_0F0F;
        start(0, SPI_RD, 7'h05, 32'h1234_5678, p, 1);
        wait_idle(0);
        start(0, SPI_WR, 7'h12, 32'hDEAD_BEEF, rand_word(), 1);
        wait_idle(0);

        // req held across two frames.
        start(0, SPI_WR, 7'h33, 32'h0BAD_F00D, rand_word(), 2);
        wait_idle(0);

        // req pulse mid-frame must be ignored.
        start(0, SPI_RD, 7'h7F, 32'h0, rand_word(), 1);
        step(60);
        req[0] = 1'b1;
        step(1);
        req[0] = 1'b0;
        wait_idle(0);

        // Reset around bit 20, then a clean frame.
        start(0, SPI_RD, 7'h41, 32'h0, rand_word(), 1);
        step((2 + 2 * 20) * 5);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(3);
        start(0, SPI_WR, 7'h2A, 32'hCAFE_0001, rand_word(), 1);
        wait_idle(0);

        for (int n = 0; n < 6; n++) begin
            start(0, 1'($urandom), 7'($urandom), $urandom(), rand_word(), 1);
            if (n % 2 == 0) wait_idle(0);
            step(int'($urandom_range(0, 3)));
        end
        wait_idle(0);

        for (int n = 0; n < 5; n++) begin
            start(1, 1'($urandom), 7'($urandom), $urandom(), rand_word(), 1);
            step(int'($urandom_range(0, 3)));
        end
        wait_idle(1);

        step(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
